// File: rtl/sha256_sigma_ch_unit.sv
// ---------------------------------------------------------------------------
// sha256_sigma_ch_unit
//
// One registered slice of the SHA-256 compression round. From the working
// variables it forms Sigma0(a), Sigma1(e) and Ch(e,f,g) combinationally and
// captures them in output registers, one clock after a valid input set. The
// results feed the T1/T2 adders of the round loop.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low (0 = in reset)
//   in_valid   a/e/f/g hold a valid set this cycle
//   a          working variable a (Sigma0 operand)
//   e          working variable e (Sigma1 operand, Ch selector)
//   f          working variable f (Ch value where e bit = 1)
//   g          working variable g (Ch value where e bit = 0)
//   out_valid  registered copy of in_valid
//   S0_val     Sigma0(a), registered
//   S1_val     Sigma1(e), registered
//   ch_val     Ch(e,f,g), registered
// ---------------------------------------------------------------------------
module sha256_sigma_ch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] e,
  input  logic [31:0] f,
  input  logic [31:0] g,
  output logic        out_valid,
  output logic [31:0] S0_val,
  output logic [31:0] S1_val,
  output logic [31:0] ch_val
);

  // 32-bit right rotate; n is always a constant 1..31 at the call sites.
  function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
    rotr = (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    big_sigma0 = rotr(x, 5'd2) ^ rotr(x, 5'd13) ^ rotr(x, 5'd22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    big_sigma1 = rotr(x, 5'd6) ^ rotr(x, 5'd11) ^ rotr(x, 5'd25);
  endfunction

  // Bitwise multiplexer: f where the selector bit is set, g otherwise.
  function automatic logic [31:0] choose(input logic [31:0] sel,
                                         input logic [31:0] x1,
                                         input logic [31:0] x0);
    choose = (sel & x1) ^ (~sel & x0);
  endfunction

  logic [31:0] s0_p0;
  logic [31:0] s1_p0;
  logic [31:0] ch_p0;

  // Stage p0: combinational round functions of the current inputs.
  always_comb begin
    s0_p0 = big_sigma0(a);
    s1_p0 = big_sigma1(e);
    ch_p0 = choose(e, f, g);
  end

  // Stage p0 -> p1: output registers. Data loads only on a valid set and
  // otherwise holds; out_valid follows in_valid every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      S0_val    <= 32'h0000_0000;
      S1_val    <= 32'h0000_0000;
      ch_val    <= 32'h0000_0000;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S0_val <= s0_p0;
        S1_val <= s1_p0;
        ch_val <= ch_p0;
      end
    end
  end

endmodule

// File: tb/tb_sha256_sigma_ch_unit.sv
// ---------------------------------------------------------------------------
// tb_sha256_sigma_ch_unit
//
// Directed bench for sha256_sigma_ch_unit: asynchronous reset behaviour,
// hand-computed vectors, Ch extremes, back-to-back streaming, hold while
// idle, reset in the middle of a stream, then a randomized run checked
// against a bit-level reference of the round functions.
// ---------------------------------------------------------------------------
module tb_sha256_sigma_ch_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] a, e, f, g;
  logic        out_valid;
  logic [31:0] S0_val, S1_val, ch_val;

  int total = 0;
  int bad   = 0;

  sha256_sigma_ch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .e         (e),
    .f         (f),
    .g         (g),
    .out_valid (out_valid),
    .S0_val    (S0_val),
    .S1_val    (S1_val),
    .ch_val    (ch_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: bit i of ROTR(x,n) is bit (i+n) mod 32 of x.
  function automatic logic [31:0] ref_rotr(input logic [31:0] x, input int n);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[(i + n) % 32];
    return r;
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return ref_rotr(x, 2) ^ ref_rotr(x, 13) ^ ref_rotr(x, 22);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return ref_rotr(x, 6) ^ ref_rotr(x, 11) ^ ref_rotr(x, 25);
  endfunction

  function automatic logic [31:0] ref_ch(input logic [31:0] s, input logic [31:0] x1,
                                         input logic [31:0] x0);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = s[i] ? x1[i] : x0[i];
    return r;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  task automatic chk_all(input string tag, input logic ov,
                         input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] ch);
    chk1 ({tag, ".out_valid"}, out_valid, ov);
    chk32({tag, ".S0_val"},    S0_val,    s0);
    chk32({tag, ".S1_val"},    S1_val,    s1);
    chk32({tag, ".ch_val"},    ch_val,    ch);
  endtask

  // Drive one set at the falling edge, then check the registered outputs
  // just after the following rising edge.
  task automatic step(input string tag, input logic v,
                      input logic [31:0] ia, input logic [31:0] ie,
                      input logic [31:0] i_f, input logic [31:0] ig,
                      input logic ov, input logic [31:0] s0,
                      input logic [31:0] s1, input logic [31:0] ch);
    @(negedge clk);
    in_valid = v; a = ia; e = ie; f = i_f; g = ig;
    @(posedge clk);
    #1;
    chk_all(tag, ov, s0, s1, ch);
  endtask

  logic        rv;
  logic [31:0] ra, re, rf, rg;
  logic [31:0] last_s0, last_s1, last_ch;

  initial begin
    rst = 1'b0; in_valid = 1'b0; a = '0; e = '0; f = '0; g = '0;

    // Reset state, and nothing loads while reset is held.
    #1;
    chk_all("reset_hold", 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    in_valid = 1'b1; a = 32'h6A09E667; e = 32'h510E527F;
    @(posedge clk); #1;
    chk_all("reset_ignores_valid", 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;

    // After release, outputs stay zero until the first valid set.
    step("idle_after_reset", 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
         1'b0, 32'h0, 32'h0, 32'h0);

    // Single-bit operands: e bit0 = 1 selects f bit0 = 1.
    step("single_bit", 1'b1, 32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'h00000000,
         1'b1, 32'h40080400, 32'h04200080, 32'h00000001);

    // SHA-256 initial hash values.
    step("round0", 1'b1, 32'h6A09E667, 32'h510E527F, 32'h9B05688C, 32'h1F83D9AB,
         1'b1, 32'hCE20B47E, 32'h3587272B, 32'h1F85C98C);

    // Ch extremes.
    step("ch_all_f", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF0,
         1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678);
    step("ch_all_g", 1'b1, 32'h00000000, 32'h00000000, 32'h12345678, 32'h9ABCDEF0,
         1'b1, 32'h00000000, 32'h00000000, 32'h9ABCDEF0);

    // Top bit of a: rotations land on bits 29, 18 and 9.
    step("msb_a", 1'b1, 32'h80000000, 32'h00000000, 32'h0, 32'h0,
         1'b1, 32'h20040200, 32'h00000000, 32'h00000000);

    // Three back-to-back sets.
    step("stream0", 1'b1, 32'h6A09E667, 32'h510E527F, 32'h9B05688C, 32'h1F83D9AB,
         1'b1, 32'hCE20B47E, 32'h3587272B, 32'h1F85C98C);
    step("stream1", 1'b1, 32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'h00000000,
         1'b1, 32'h40080400, 32'h04200080, 32'h00000001);
    step("stream2", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF0,
         1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678);

    // Idle with changing inputs: hold last results.
    step("hold0", 1'b0, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0F0F0F0F, 32'hF0F0F0F0,
         1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678);
    step("hold1", 1'b0, 32'h01234567, 32'h89ABCDEF, 32'hAAAAAAAA, 32'h55555555,
         1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678);

    // Asynchronous reset mid-cycle with a valid set in flight.
    step("pre_reset", 1'b1, 32'h6A09E667, 32'h510E527F, 32'h9B05688C, 32'h1F83D9AB,
         1'b1, 32'hCE20B47E, 32'h3587272B, 32'h1F85C98C);
    @(negedge clk);
    in_valid = 1'b1; a = 32'h00000001; e = 32'h00000001; f = 32'hFFFFFFFF; g = 32'h0;
    #2 rst = 1'b0;
    #1;
    chk_all("async_reset", 1'b0, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk_all("reset_discard", 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    a = 32'h6A09E667; e = 32'h510E527F; f = 32'h9B05688C; g = 32'h1F83D9AB;
    @(posedge clk); #1;
    chk_all("first_after_reset", 1'b1, 32'hCE20B47E, 32'h3587272B, 32'h1F85C98C);

    // Randomized run against the bit-level reference.
    last_s0 = 32'hCE20B47E; last_s1 = 32'h3587272B; last_ch = 32'h1F85C98C;
    for (int i = 0; i < 10000; i++) begin
      rv = 1'($urandom_range(0, 1));
      ra = $urandom; re = $urandom; rf = $urandom; rg = $urandom;
      if (rv) begin
        last_s0 = ref_s0(ra);
        last_s1 = ref_s1(re);
        last_ch = ref_ch(re, rf, rg);
      end
      step("random", rv, ra, re, rf, rg, rv, last_s0, last_s1, last_ch);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
